// File: rtl/bus_monitor.sv
// Bus monitor: watches a core memory bus, traces MMIO accesses into a FIFO, detects halt/watchdog timeout.
// Latency: capture-to-trace_valid 1 cycle (no empty-FIFO bypass); halt/timeout flags assert 1 cycle after the trigger.
// Backpressure: trace_ready stalls the FIFO head; captures arriving while full (and not popping) are dropped and counted.
//
// Ports:
//   clk, resetn                      single clock, asynchronous active-low reset
//   bus_address/_data_out/_data_in   observed core bus (address, write data, read data)
//   bus_we                           write enable of the observed access
//   trace_valid/_ready               valid/ready handshake of the trace FIFO head
//   trace_addr/_data/_we/_cycle      head entry fields (all zero while the FIFO is empty)
//   halt, timeout                    sticky status flags
//   cycle_count, dropped_count       run-cycle counter and dropped-capture counter (both saturating)
//
// Build option: define BUS_MONITOR_CYCLE_STAMP_EN to store cycle_count with each entry and drive
// trace_cycle; otherwise no timestamp storage exists and trace_cycle is tied to zero.

// Generic FIFO: DEPTH entries of W bits with a valid/ready write and read side.
// Latency: written entry visible on rd_dat 1 cycle later; no write-to-read bypass.
// Backpressure: wr_rdy low only when full and not popping this cycle; rd_dat holds while rd_rdy low.
module bus_monitor_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int PW = $clog2(DEPTH);

  // One extra pointer bit tells full from empty when the index bits match.
  logic [PW:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         full;
  logic         do_wr;
  logic         do_rd;

  assign rd_vld = (wr_ptr_q != rd_ptr_q);
  assign full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_rd  = rd_vld && rd_rdy;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside a read.
  assign wr_rdy = !full || do_rd;
  assign do_wr  = wr_vld && wr_rdy;

  assign wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
  assign rd_dat = rd_vld ? mem_q[rd_ptr_q[PW-1:0]] : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[PW-1:0]] <= wr_dat;
    end
  end
endmodule

module bus_monitor #(
  parameter int            AW             = 32,
  parameter int            DW             = 32,
  parameter logic [AW-1:0] MMIO_BASE      = 'h800,
  parameter logic [AW-1:0] MMIO_MASK      = 'h800,
  parameter logic [AW-1:0] HALT_ADDR      = 'hFFC,
  parameter int            TIMEOUT_CYCLES = 2000,
  parameter int            FIFO_DEPTH     = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] bus_address,
  input  logic [DW-1:0] bus_data_out,
  input  logic [DW-1:0] bus_data_in,
  input  logic          bus_we,
  output logic          trace_valid,
  input  logic          trace_ready,
  output logic [AW-1:0] trace_addr,
  output logic [DW-1:0] trace_data,
  output logic          trace_we,
  output logic [31:0]   trace_cycle,
  output logic          halt,
  output logic          timeout,
  output logic [31:0]   cycle_count,
  output logic [15:0]   dropped_count
);
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALTED    = 2'd1,
    ST_TIMED_OUT = 2'd2
  } state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
`ifdef BUS_MONITOR_CYCLE_STAMP_EN
    logic [31:0]   cyc;
`endif
  } entry_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [15:0] dropped_count_q, dropped_count_d;

  logic   halt_hit;
  logic   mmio_hit;
  logic   push_vld;
  logic   push_rdy;
  entry_t push_dat;
  entry_t head_dat;

  assign halt_hit = (bus_address == HALT_ADDR);
  assign mmio_hit = ((bus_address & MMIO_MASK) == MMIO_BASE);
  // The halt address is never traced, even when it falls inside the MMIO window.
  assign push_vld = (state_q == ST_RUN) && mmio_hit && !halt_hit;

  always_comb begin
    push_dat      = '0;
    push_dat.addr = bus_address;
    push_dat.data = bus_we ? bus_data_out : bus_data_in;
    push_dat.we   = bus_we;
`ifdef BUS_MONITOR_CYCLE_STAMP_EN
    push_dat.cyc  = cycle_count_q;
`endif
  end

  bus_monitor_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .wr_vld (push_vld),
    .wr_rdy (push_rdy),
    .wr_dat (push_dat),
    .rd_vld (trace_valid),
    .rd_rdy (trace_ready),
    .rd_dat (head_dat)
  );

  assign trace_addr = head_dat.addr;
  assign trace_data = head_dat.data;
  assign trace_we   = head_dat.we;
`ifdef BUS_MONITOR_CYCLE_STAMP_EN
  assign trace_cycle = head_dat.cyc;
`else
  assign trace_cycle = 32'd0;
`endif

  // Next state, cycle counter and status flags. The counter still advances on the
  // cycle that leaves RUN, so it freezes one past the triggering value.
  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    halt          = 1'b0;
    timeout       = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (cycle_count_q != 32'hFFFF_FFFF) begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
        // Halt has priority over a simultaneous watchdog expiry.
        if (halt_hit) begin
          state_d = ST_HALTED;
        end else if ((TIMEOUT_CYCLES != 0) && (cycle_count_q == TO_LAST)) begin
          state_d = ST_TIMED_OUT;
        end
      end
      ST_HALTED: begin
        halt = 1'b1;
      end
      ST_TIMED_OUT: begin
        timeout = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    dropped_count_d = dropped_count_q;
    if (push_vld && !push_rdy && (dropped_count_q != 16'hFFFF)) begin
      dropped_count_d = dropped_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_RUN;
      cycle_count_q   <= 32'd0;
      dropped_count_q <= 16'd0;
    end else begin
      state_q         <= state_d;
      cycle_count_q   <= cycle_count_d;
      dropped_count_q <= dropped_count_d;
    end
  end

  assign cycle_count   = cycle_count_q;
  assign dropped_count = dropped_count_q;
endmodule

// File: tb/tb_bus_monitor.sv
// Testbench for bus_monitor: directed scenarios plus randomized traffic against a queue-based reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: trace_ready driven directly by the bench (held low, high, or random).
module tb_bus_monitor;
  localparam int DEPTH   = 8;
  localparam int M_TO    = 150;
  localparam int M_TO_B  = 20;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] bus_address;
  logic [31:0] bus_data_out;
  logic [31:0] bus_data_in;
  logic        bus_we;
  logic        trace_ready;

  logic        trace_valid, trace_we, halt, timeout;
  logic [31:0] trace_addr, trace_data, trace_cycle, cycle_count;
  logic [15:0] dropped_count;

  logic        v2, w2, h2, t2;
  logic [31:0] a2, d2, c2, cc2;
  logic [15:0] dc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_monitor #(.TIMEOUT_CYCLES(M_TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .bus_address(bus_address), .bus_data_out(bus_data_out),
    .bus_data_in(bus_data_in), .bus_we(bus_we), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_addr(trace_addr), .trace_data(trace_data), .trace_we(trace_we), .trace_cycle(trace_cycle),
    .halt(halt), .timeout(timeout), .cycle_count(cycle_count), .dropped_count(dropped_count)
  );

  bus_monitor #(.TIMEOUT_CYCLES(M_TO_B), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .resetn(resetn), .bus_address(bus_address), .bus_data_out(bus_data_out),
    .bus_data_in(bus_data_in), .bus_we(bus_we), .trace_valid(v2), .trace_ready(trace_ready),
    .trace_addr(a2), .trace_data(d2), .trace_we(w2), .trace_cycle(c2),
    .halt(h2), .timeout(t2), .cycle_count(cc2), .dropped_count(dc2)
  );

  // Reference model: the trace FIFO is a plain queue of captured accesses.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic [31:0] cyc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_cc;
  logic [15:0] m_drop;
  bit          m_halt, m_to;

  function automatic void m_reset();
    mq.delete();
    m_cc   = 32'd0;
    m_drop = 16'd0;
    m_halt = 1'b0;
    m_to   = 1'b0;
  endfunction

  function automatic void model_step();
    bit   run, cap, pop, room;
    ent_t e;
    run  = !m_halt && !m_to;
    cap  = run && (bus_address[11] == 1'b1) && (bus_address != 32'hFFC);
    pop  = (mq.size() != 0) && trace_ready;
    room = (mq.size() < DEPTH) || pop;
    if (pop) mq.delete(0);
    if (cap) begin
      if (room) begin
        e.addr = bus_address;
        e.data = bus_we ? bus_data_out : bus_data_in;
        e.we   = bus_we;
        e.cyc  = m_cc;
        mq.push_back(e);
      end else if (m_drop != 16'hFFFF) begin
        m_drop = m_drop + 16'd1;
      end
    end
    if (run) begin
      if (bus_address == 32'hFFC) m_halt = 1'b1;
      else if (m_cc == 32'(M_TO - 1)) m_to = 1'b1;
      if (m_cc != 32'hFFFF_FFFF) m_cc = m_cc + 32'd1;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    ent_t        h;
    logic        ev;
    logic [31:0] ecyc;
    ev = (mq.size() != 0);
    if (ev) h = mq[0];
    else begin
      h.addr = 32'd0; h.data = 32'd0; h.we = 1'b0; h.cyc = 32'd0;
    end
`ifdef BUS_MONITOR_CYCLE_STAMP_EN
    ecyc = h.cyc;
`else
    ecyc = 32'd0;
`endif
    chk("trace_valid", trace_valid, ev);
    chk("trace_addr", trace_addr, h.addr);
    chk("trace_data", trace_data, h.data);
    chk("trace_we", trace_we, h.we);
    chk("trace_cycle", trace_cycle, ecyc);
    chk("halt", halt, m_halt);
    chk("timeout", timeout, m_to);
    chk("cycle_count", cycle_count, m_cc);
    chk("dropped_count", dropped_count, m_drop);
  endtask

  task automatic tick();
    @(posedge clk);
    if (resetn) model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    bus_address  = 32'd0;
    bus_we       = 1'b0;
    bus_data_out = 32'd0;
    bus_data_in  = 32'd0;
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    m_reset();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    resetn      = 1'b0;
    trace_ready = 1'b0;
    idle();
    m_reset();
    #1;
    chk("rst_valid", trace_valid, 1'b0);
    chk("rst_addr", trace_addr, 32'd0);
    chk("rst_halt", halt, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_dropped", dropped_count, 16'd0);
    tick();
    resetn = 1'b1;

    // Single MMIO write shows up at the head one cycle later.
    bus_address = 32'h800; bus_we = 1'b1; bus_data_out = 32'h2A; trace_ready = 1'b1;
    tick();
    chk("wr_valid", trace_valid, 1'b1);
    chk("wr_addr", trace_addr, 32'h800);
    chk("wr_data", trace_data, 32'h2A);
    chk("wr_we", trace_we, 1'b1);
    idle();
    tick();
    chk("wr_drained", trace_valid, 1'b0);

    // Ten reads with the consumer stalled: eight held, two dropped.
    trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus_address = 32'h800 + 32'(4 * i);
      bus_data_in = $urandom;
      tick();
    end
    chk("ovf_dropped", dropped_count, 16'd2);
    chk("ovf_head", trace_addr, 32'h800);

    // Full FIFO, pop and new hit together: accepted, no drop.
    bus_address = 32'h900; bus_data_in = 32'h1234; trace_ready = 1'b1;
    tick();
    chk("fullpop_dropped", dropped_count, 16'd2);
    idle();
    for (int i = 1; i <= 8; i++) begin
      chk("drain_addr", trace_addr, (i == 8) ? 32'h900 : 32'h800 + 32'(4 * i));
      tick();
    end
    chk("drain_empty", trace_valid, 1'b0);

    // Halt at cycle 37 with entries queued, then reset mid-run.
    pulse_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 33; i++) tick();
    for (int i = 0; i < 4; i++) begin
      bus_address = 32'hA00 + 32'(4 * i);
      bus_data_in = $urandom;
      tick();
    end
    chk("pre_halt_cc", cycle_count, 32'd37);
    bus_address = 32'hFFC;
    tick();
    chk("halt_set", halt, 1'b1);
    chk("halt_cc", cycle_count, 32'd38);
    idle();
    tick();
    chk("halt_frozen", cycle_count, 32'd38);
    chk("halt_head", trace_addr, 32'hA00);
    trace_ready = 1'b1;
    tick();
    chk("halt_drain", trace_addr, 32'hA04);
    trace_ready = 1'b0;
    resetn = 1'b0;
    m_reset();
    #1;
    chk("mrst_valid", trace_valid, 1'b0);
    chk("mrst_addr", trace_addr, 32'd0);
    chk("mrst_data", trace_data, 32'd0);
    chk("mrst_we", trace_we, 1'b0);
    chk("mrst_cycle", trace_cycle, 32'd0);
    chk("mrst_halt", halt, 1'b0);
    chk("mrst_cc", cycle_count, 32'd0);
    tick();
    resetn = 1'b1;
    bus_address = 32'hC00; bus_we = 1'b1; bus_data_out = 32'h55;
    tick();
    chk("restart_valid", trace_valid, 1'b1);
    chk("restart_addr", trace_addr, 32'hC00);
    chk("restart_cycle", trace_cycle, 32'd0);
    chk("restart_cc", cycle_count, 32'd1);
    idle();

    // Watchdog on the 20-cycle instance.
    pulse_reset();
    trace_ready = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      tick();
      chk("wd_cc", cc2, (k >= 20) ? 32'd20 : 32'(k));
      chk("wd_timeout", t2, (k >= 20) ? 1'b1 : 1'b0);
    end
    pulse_reset();
    for (int k = 0; k < 19; k++) tick();
    bus_address = 32'hFFC;
    tick();
    chk("wd_halt", h2, 1'b1);
    chk("wd_halt_to", t2, 1'b0);
    idle();
    tick();
    chk("wd_halt_to2", t2, 1'b0);

    // Randomized traffic with a mid-run reset.
    pulse_reset();
    for (int i = 0; i < 320; i++) begin
      if (i == 140) pulse_reset();
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: bus_address = ($urandom | 32'h800) & ~32'hFFF | 32'h800 | (32'($urandom_range(0, 255)) << 2);
        default: bus_address = $urandom & ~32'h800;
      endcase
      if ($urandom_range(0, 199) == 0) bus_address = 32'hFFC;
      bus_we       = 1'($urandom);
      bus_data_out = $urandom;
      bus_data_in  = $urandom;
      trace_ready  = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_monitor.md
BUS_MONITOR -- requirements
Module: bus_monitor

Interface
REQ-001 SHALL have parameter AW, default 32, meaning bus address width.
REQ-002 SHALL have parameter DW, default 32, meaning bus data width.
REQ-003 SHALL have parameter MMIO_BASE, default 'h800, meaning MMIO window base; hit when (bus_address & MMIO_MASK) == MMIO_BASE.
REQ-004 SHALL have parameter MMIO_MASK, default 'h800, meaning MMIO window decode mask.
REQ-005 SHALL have parameter HALT_ADDR, default 'hFFC, meaning halt-detect address.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 2000, meaning watchdog limit in cycles; 0 disables the watchdog.
REQ-007 SHALL have parameter FIFO_DEPTH, default 8, meaning trace FIFO entries; power of two, at least 2.
REQ-008 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-009 SHALL have port resetn, input, 1 bit, meaning asynchronous active-low reset.
REQ-010 SHALL have port bus_address, input, AW bits, meaning core memory address.
REQ-011 SHALL have port bus_data_out, input, DW bits, meaning core write data.
REQ-012 SHALL have port bus_data_in, input, DW bits, meaning memory read data.
REQ-013 SHALL have port bus_we, input, 1 bit, meaning write enable.
REQ-014 SHALL have ports trace_valid (output, 1), trace_ready (input, 1), trace_addr (output, AW), trace_data (output, DW), trace_we (output, 1) and trace_cycle (output, 32), forming the trace FIFO head.
REQ-015 SHALL have outputs halt (1), timeout (1), cycle_count (32) and dropped_count (16).

Function
REQ-016 SHALL implement state machine RUN, HALTED and TIMED_OUT; RUN is entered from reset.
REQ-017 In RUN, bus_address == HALT_ADDR SHALL move the state to HALTED; halt becomes 1 on the next cycle and stays 1 (sticky).
REQ-018 In RUN, with TIMEOUT_CYCLES != 0, cycle_count == TIMEOUT_CYCLES-1 SHALL move the state to TIMED_OUT; timeout becomes 1 on the next cycle and stays 1 (sticky).
REQ-019 When halt and timeout conditions occur in the same cycle, halt SHALL win.
REQ-020 cycle_count SHALL increment by 1 per cycle in RUN only, be frozen in HALTED and TIMED_OUT, and saturate at 2^32-1.
REQ-021 In RUN, each cycle with an MMIO hit and no halt match SHALL push {bus_address, bus_we ? bus_data_out : bus_data_in, bus_we, cycle_count}; repeated cycles on the same address each push.
REQ-022 A halt-address cycle SHALL never be captured, even if it decodes as MMIO.
REQ-023 No capture SHALL occur outside RUN.
REQ-024 FIFO pop SHALL occur when trace_valid && trace_ready; trace_valid = FIFO non-empty; head fields SHALL be stable while trace_valid=1 and trace_ready=0.
REQ-025 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-026 Otherwise the push SHALL be dropped and dropped_count incremented, saturating at 16'hFFFF.
REQ-027 Capture-to-trace_valid latency SHALL be 1 cycle when the FIFO is empty.
REQ-028 Push and pop on an empty FIFO SHALL not bypass: the new entry appears next cycle.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 FIFO drain SHALL continue to work in HALTED and TIMED_OUT.

Reset
REQ-031 resetn=0 SHALL immediately, asynchronously, set: state RUN, halt=0, timeout=0, cycle_count=0, dropped_count=0, FIFO empty, trace_valid=0.
REQ-032 When resetn=0, trace_addr, trace_data, trace_we and trace_cycle SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard all FIFO contents and sticky flags.
REQ-034 Capture SHALL resume on the first rising edge after resetn deasserts.

Configuration
REQ-035 With macro BUS_MONITOR_CYCLE_STAMP_EN defined, each FIFO entry SHALL store cycle_count at capture and trace_cycle SHALL output it.
REQ-036 Without BUS_MONITOR_CYCLE_STAMP_EN, no timestamp storage SHALL exist and trace_cycle SHALL be tied to 0.

Verification
REQ-037 SHALL verify: write 0x2A to 0x800, trace_ready=1 -> next cycle trace_valid=1, trace_addr=0x800, trace_data=0x2A, trace_we=1.
REQ-038 SHALL verify: trace_ready=0, 10 MMIO reads, FIFO_DEPTH=8 -> 8 entries held in order, dropped_count=2, drain returns the first 8 addresses.
REQ-039 SHALL verify: bus_address=0xFFC at cycle_count=37 -> halt=1 next cycle, cycle_count frozen at 38, no trace entry, earlier entries still drainable.
REQ-040 SHALL verify: TIMEOUT_CYCLES=20, no halt address -> timeout=1 when cycle_count=20; with 0xFFC on cycle 19, halt=1 and timeout=0.
REQ-041 SHALL verify: FIFO full with trace_ready=1 and a new MMIO hit in the same cycle -> push accepted, dropped_count unchanged.
REQ-042 SHALL verify: resetn pulsed low mid-run with 3 entries queued and halt=1 -> all outputs 0 during reset; capture restarts at cycle_count=0.
